// File: rtl/ysyx_25030093_trap_ctrl_pkg.sv
// Shared definitions for the trap sequencer: CSR addresses, cause codes,
// mstatus field positions, request encodings and the sequencer state type.
package ysyx_25030093_trap_ctrl_pkg;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;

    localparam int CAUSE_ECALL_M    = 11;
    localparam int CAUSE_BREAKPOINT = 3;

    localparam int MIE_BIT  = 3;
    localparam int MPIE_BIT = 7;
    localparam int MPP_HI   = 12;
    localparam int MPP_LO   = 11;

    typedef enum logic [1:0] {
        KIND_ECALL  = 2'd0,
        KIND_EBREAK = 2'd1,
        KIND_MRET   = 2'd2,
        KIND_RSVD   = 2'd3
    } kind_e;

    // S_NOP is the single busy cycle spent on a reserved request.
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_W_EPC   = 3'd1,
        S_W_CAUSE = 3'd2,
        S_W_STAT  = 3'd3,
        S_RD_TGT  = 3'd4,
        S_REDIR   = 3'd5,
        S_NOP     = 3'd6
    } state_e;

endpackage

// File: rtl/ysyx_25030093_mstatus_upd.sv
// Combinational mstatus rewrite: trap entry stacks MIE into MPIE, mret
// restores MIE from MPIE. Both force MPP to machine mode.
module ysyx_25030093_mstatus_upd
    import ysyx_25030093_trap_ctrl_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] old_status,
    input  logic [1:0]      kind,
    output logic [XLEN-1:0] new_status
);

    always_comb begin
        new_status = old_status;
        new_status[MPP_HI:MPP_LO] = 2'b11;
        if (kind == KIND_MRET) begin
            new_status[MIE_BIT]  = old_status[MPIE_BIT];
            new_status[MPIE_BIT] = 1'b1;
        end else begin
            new_status[MPIE_BIT] = old_status[MIE_BIT];
            new_status[MIE_BIT]  = 1'b0;
        end
    end

endmodule

// File: rtl/ysyx_25030093_trap_ctrl.sv
// Trap sequencer: performs the ecall/ebreak/mret CSR side effects one write
// per cycle, then fetches the target CSR and offers a PC redirect.
module ysyx_25030093_trap_ctrl
    import ysyx_25030093_trap_ctrl_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int CSR_AW = 12
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_kind,
    input  logic [XLEN-1:0]   req_pc,
    output logic [CSR_AW-1:0] csr_raddr,
    input  logic [XLEN-1:0]   csr_rdata,
    output logic [CSR_AW-1:0] csr_waddr,
    output logic [XLEN-1:0]   csr_wdata,
    output logic              csr_wen,
    output logic              redir_valid,
    output logic [XLEN-1:0]   redir_pc,
    input  logic              redir_ready,
    output logic              busy,
    output state_e            state
);

    // Handshakes: req is taken when req_valid && req_ready (IDLE only);
    // redirect completes when redir_valid && redir_ready, after which the
    // sequencer spends one cycle in IDLE before it can accept again.

    localparam logic [XLEN-1:0] ALIGN_MASK = {{(XLEN-2){1'b1}}, 2'b00};

    state_e          state_next;
    logic [XLEN-1:0] pc_q;
    kind_e           kind_q;
    logic [XLEN-1:0] redir_pc_q;
    logic [XLEN-1:0] status_new;
    logic            wen_raw;

    ysyx_25030093_mstatus_upd #(.XLEN(XLEN)) u_mstatus_upd (
        .old_status (csr_rdata),
        .kind       (kind_q),
        .new_status (status_new)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= S_IDLE;
            pc_q       <= '0;
            kind_q     <= KIND_ECALL;
            redir_pc_q <= '0;
        end else begin
            state <= state_next;
            if (req_valid && state == S_IDLE) begin
                pc_q   <= req_pc;
                kind_q <= kind_e'(req_kind);
            end
            if (state == S_RD_TGT) begin
                redir_pc_q <= csr_rdata & ALIGN_MASK;
            end
        end
    end

    always_comb begin
        state_next = state;
        csr_raddr  = '0;
        csr_waddr  = '0;
        csr_wdata  = '0;
        wen_raw    = 1'b0;
        case (state)
            S_IDLE: begin
                if (req_valid) begin
                    case (kind_e'(req_kind))
                        KIND_ECALL, KIND_EBREAK: state_next = S_W_EPC;
                        KIND_MRET:               state_next = S_W_STAT;
                        default:                 state_next = S_NOP;
                    endcase
                end
            end
            S_W_EPC: begin
                wen_raw    = 1'b1;
                csr_waddr  = CSR_AW'(CSR_MEPC);
                csr_wdata  = pc_q & ALIGN_MASK;
                state_next = S_W_CAUSE;
            end
            S_W_CAUSE: begin
                wen_raw    = 1'b1;
                csr_waddr  = CSR_AW'(CSR_MCAUSE);
                csr_wdata  = (kind_q == KIND_EBREAK) ? XLEN'(CAUSE_BREAKPOINT)
                                                     : XLEN'(CAUSE_ECALL_M);
                state_next = S_W_STAT;
            end
            S_W_STAT: begin
                // Read-modify-write in one cycle: the CSR file reads combinationally.
                csr_raddr  = CSR_AW'(CSR_MSTATUS);
                wen_raw    = 1'b1;
                csr_waddr  = CSR_AW'(CSR_MSTATUS);
                csr_wdata  = status_new;
                state_next = S_RD_TGT;
            end
            S_RD_TGT: begin
                csr_raddr  = (kind_q == KIND_MRET) ? CSR_AW'(CSR_MEPC) : CSR_AW'(CSR_MTVEC);
                state_next = S_REDIR;
            end
            S_REDIR: begin
                if (redir_ready) state_next = S_IDLE;
            end
            S_NOP:   state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // A reset landing mid-sequence must not let the pending write commit.
    assign csr_wen     = wen_raw & ~reset;
    assign req_ready   = (state == S_IDLE);
    assign busy        = (state != S_IDLE);
    assign redir_valid = (state == S_REDIR);
    assign redir_pc    = redir_pc_q;

endmodule

// File: tb/tb_ysyx_25030093_trap_ctrl.sv
// Directed bench for the trap sequencer and its mstatus update block,
// backed by a small behavioural CSR file that logs every committed write.
module tb_ysyx_25030093_trap_ctrl;
    import ysyx_25030093_trap_ctrl_pkg::*;

    localparam int XLEN   = 32;
    localparam int CSR_AW = 12;

    // ---------------- clock / reset ----------------
    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    logic              req_valid = 1'b0;
    logic              req_ready;
    logic [1:0]        req_kind = 2'd0;
    logic [XLEN-1:0]   req_pc = '0;
    logic [CSR_AW-1:0] csr_raddr;
    logic [XLEN-1:0]   csr_rdata;
    logic [CSR_AW-1:0] csr_waddr;
    logic [XLEN-1:0]   csr_wdata;
    logic              csr_wen;
    logic              redir_valid;
    logic [XLEN-1:0]   redir_pc;
    logic              redir_ready = 1'b0;
    logic              busy;
    state_e            state;

    ysyx_25030093_trap_ctrl #(.XLEN(XLEN), .CSR_AW(CSR_AW)) dut (
        .clock       (clock),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_kind    (req_kind),
        .req_pc      (req_pc),
        .csr_raddr   (csr_raddr),
        .csr_rdata   (csr_rdata),
        .csr_waddr   (csr_waddr),
        .csr_wdata   (csr_wdata),
        .csr_wen     (csr_wen),
        .redir_valid (redir_valid),
        .redir_pc    (redir_pc),
        .redir_ready (redir_ready),
        .busy        (busy),
        .state       (state)
    );

    logic [XLEN-1:0] upd_old = '0;
    logic [1:0]      upd_kind = 2'd0;
    logic [XLEN-1:0] upd_new;

    ysyx_25030093_mstatus_upd #(.XLEN(XLEN)) u_upd (
        .old_status (upd_old),
        .kind       (upd_kind),
        .new_status (upd_new)
    );

    // ---------------- CSR file model ----------------
    logic [XLEN-1:0] m_status, m_epc, m_cause, m_tvec;
    logic [XLEN-1:0] seed_status = '0, seed_epc = '0, seed_tvec = '0;
    logic            seed_en = 1'b0;
    int              cyc = 0;
    logic [43:0]     wlog[$];
    int              wcyc[$];
    logic [43:0]     exp_q[$];

    always_comb begin
        case (csr_raddr)
            CSR_MSTATUS: csr_rdata = m_status;
            CSR_MEPC:    csr_rdata = m_epc;
            CSR_MCAUSE:  csr_rdata = m_cause;
            CSR_MTVEC:   csr_rdata = m_tvec;
            default:     csr_rdata = '0;
        endcase
    end

    always @(posedge clock) begin
        cyc <= cyc + 1;
        if (seed_en) begin
            m_status <= seed_status;
            m_epc    <= seed_epc;
            m_tvec   <= seed_tvec;
            m_cause  <= '0;
        end else if (csr_wen) begin
            case (csr_waddr)
                CSR_MSTATUS: m_status <= csr_wdata;
                CSR_MEPC:    m_epc    <= csr_wdata;
                CSR_MCAUSE:  m_cause  <= csr_wdata;
                CSR_MTVEC:   m_tvec   <= csr_wdata;
                default: ;
            endcase
            wlog.push_back({csr_waddr, csr_wdata});
            wcyc.push_back(cyc);
        end
    end

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic check_log(input string name);
        int n;
        check({name, " write count"}, XLEN'(wlog.size()), XLEN'(exp_q.size()));
        n = (wlog.size() < exp_q.size()) ? wlog.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s write%0d addr", name, i), XLEN'(wlog[i][43:32]), XLEN'(exp_q[i][43:32]));
            check($sformatf("%s write%0d data", name, i), wlog[i][31:0], exp_q[i][31:0]);
            if (i > 0)
                check($sformatf("%s write%0d back-to-back", name, i), XLEN'(wcyc[i] - wcyc[i-1]), 32'd1);
        end
        wlog.delete();
        wcyc.delete();
        exp_q.delete();
    endtask

    // ---------------- driver tasks ----------------
    task automatic seed(input logic [XLEN-1:0] st, input logic [XLEN-1:0] ep, input logic [XLEN-1:0] tv);
        @(negedge clock);
        seed_status = st;
        seed_epc    = ep;
        seed_tvec   = tv;
        seed_en     = 1'b1;
        @(negedge clock);
        seed_en = 1'b0;
    endtask

    task automatic run_trap(input string name, input logic [1:0] kind, input logic [XLEN-1:0] pc,
                            input int exp_lat, input logic [XLEN-1:0] exp_pc, input int stall);
        int lat;
        logic [XLEN-1:0] first_pc;
        @(negedge clock);
        check({name, " req_ready before"}, XLEN'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_kind  = kind;
        req_pc    = pc;
        @(negedge clock);
        req_valid = 1'b0;
        lat = 1;
        while (!redir_valid && lat < 20) begin
            @(negedge clock);
            lat++;
        end
        check({name, " latency"}, XLEN'(lat), XLEN'(exp_lat));
        check({name, " redir_pc"}, redir_pc, exp_pc);
        first_pc = redir_pc;
        for (int i = 0; i < stall; i++) begin
            check($sformatf("%s stall%0d redir_valid", name, i), XLEN'(redir_valid), 32'd1);
            check($sformatf("%s stall%0d redir_pc", name, i), redir_pc, first_pc);
            check($sformatf("%s stall%0d req_ready", name, i), XLEN'(req_ready), 32'd0);
            @(negedge clock);
        end
        redir_ready = 1'b1;
        @(negedge clock);
        redir_ready = 1'b0;
        check({name, " redir_valid after"}, XLEN'(redir_valid), 32'd0);
        check({name, " req_ready after"}, XLEN'(req_ready), 32'd1);
    endtask

    // ---------------- mstatus update table ----------------
    typedef struct {
        logic [XLEN-1:0] old_v;
        logic [1:0]      kind;
        logic [XLEN-1:0] exp_v;
    } upd_vec_t;

    upd_vec_t upd_tbl[8];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        upd_tbl[0] = '{32'h0000_0008, KIND_ECALL,  32'h0000_1880};
        upd_tbl[1] = '{32'h0000_0000, KIND_EBREAK, 32'h0000_1800};
        upd_tbl[2] = '{32'hFFFF_FFFF, KIND_ECALL,  32'hFFFF_FFF7};
        upd_tbl[3] = '{32'hFFFF_FFF7, KIND_EBREAK, 32'hFFFF_FF77};
        upd_tbl[4] = '{32'h0000_1880, KIND_MRET,   32'h0000_1888};
        upd_tbl[5] = '{32'h0000_0000, KIND_MRET,   32'h0000_1880};
        upd_tbl[6] = '{32'hFFFF_FF7F, KIND_MRET,   32'hFFFF_FFF7};
        upd_tbl[7] = '{32'h0000_0008, KIND_MRET,   32'h0000_1880};

        for (int i = 0; i < 8; i++) begin
            upd_old  = upd_tbl[i].old_v;
            upd_kind = upd_tbl[i].kind;
            #1;
            check($sformatf("mstatus_upd vec%0d", i), upd_new, upd_tbl[i].exp_v);
        end

        // Reset state
        repeat (2) @(negedge clock);
        check("reset state",       {29'b0, state}, {29'b0, S_IDLE});
        check("reset csr_wen",     XLEN'(csr_wen), 32'd0);
        reset = 1'b0;
        @(negedge clock);
        check("reset req_ready",   XLEN'(req_ready), 32'd1);
        check("reset busy",        XLEN'(busy), 32'd0);
        check("reset redir_valid", XLEN'(redir_valid), 32'd0);
        check("reset redir_pc",    redir_pc, 32'd0);

        // Ecall, aligned pc
        seed(32'h0000_0008, 32'h0, 32'h8000_0200);
        exp_q.push_back({CSR_MEPC,    32'h8000_0104});
        exp_q.push_back({CSR_MCAUSE,  32'd11});
        exp_q.push_back({CSR_MSTATUS, 32'h0000_1880});
        run_trap("ecall", KIND_ECALL, 32'h8000_0104, 5, 32'h8000_0200, 0);
        check_log("ecall");

        // Mret
        seed(32'h0000_1880, 32'h8000_0108, 32'h8000_0200);
        exp_q.push_back({CSR_MSTATUS, 32'h0000_1888});
        run_trap("mret", KIND_MRET, 32'h8000_0300, 3, 32'h8000_0108, 0);
        check_log("mret");

        // Ecall with misaligned pc and mtvec mode bits set
        seed(32'h0000_0000, 32'h0, 32'h8000_0203);
        exp_q.push_back({CSR_MEPC,    32'h8000_0104});
        exp_q.push_back({CSR_MCAUSE,  32'd11});
        exp_q.push_back({CSR_MSTATUS, 32'h0000_1800});
        run_trap("ecall_mask", KIND_ECALL, 32'h8000_0106, 5, 32'h8000_0200, 0);
        check_log("ecall_mask");

        // Ebreak with the IFU stalling the redirect
        seed(32'h0000_0088, 32'h0, 32'h8000_0100);
        exp_q.push_back({CSR_MEPC,    32'h8000_0010});
        exp_q.push_back({CSR_MCAUSE,  32'd3});
        exp_q.push_back({CSR_MSTATUS, 32'h0000_1880});
        run_trap("ebreak_stall", KIND_EBREAK, 32'h8000_0010, 5, 32'h8000_0100, 4);
        check_log("ebreak_stall");

        // Reserved kind: one busy cycle, nothing else
        @(negedge clock);
        req_valid = 1'b1;
        req_kind  = KIND_RSVD;
        req_pc    = 32'h8000_0400;
        @(negedge clock);
        req_valid = 1'b0;
        check("rsvd busy",      XLEN'(busy), 32'd1);
        check("rsvd req_ready", XLEN'(req_ready), 32'd0);
        @(negedge clock);
        check("rsvd req_ready after", XLEN'(req_ready), 32'd1);
        check("rsvd state",     {29'b0, state}, {29'b0, S_IDLE});
        for (int i = 0; i < 6; i++) begin
            check($sformatf("rsvd redir_valid%0d", i), XLEN'(redir_valid), 32'd0);
            @(negedge clock);
        end
        check_log("rsvd");

        // Reset landing in W_CAUSE
        seed(32'h0000_0008, 32'h0, 32'h8000_0200);
        @(negedge clock);
        req_valid = 1'b1;
        req_kind  = KIND_ECALL;
        req_pc    = 32'h8000_0020;
        @(negedge clock);
        req_valid = 1'b0;
        @(negedge clock);
        check("abort in W_CAUSE", {29'b0, state}, {29'b0, S_W_CAUSE});
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check("abort state",       {29'b0, state}, {29'b0, S_IDLE});
        check("abort busy",        XLEN'(busy), 32'd0);
        check("abort redir_valid", XLEN'(redir_valid), 32'd0);
        check("abort req_ready",   XLEN'(req_ready), 32'd1);
        for (int i = 0; i < 6; i++) begin
            check($sformatf("abort quiet%0d", i), XLEN'(redir_valid | csr_wen), 32'd0);
            @(negedge clock);
        end
        exp_q.push_back({CSR_MEPC, 32'h8000_0020});
        check_log("abort");
        check("abort mstatus kept", m_status, 32'h0000_0008);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ysyx_25030093_trap_ctrl.md
Name: ysyx_25030093_trap_ctrl

Overview:
Multi-cycle trap sequencer between the EXU and the CSR register file. Accepts ecall, ebreak or mret requests and performs the CSR side effects one write per cycle through the CSR file's single write port (mepc, mcause, mstatus). It then reads the target CSR (mtvec or mepc) and presents a PC redirect to the IFU under a valid/ready handshake. Exactly one trap is in flight at a time.

Parameters:
XLEN, 32, data width of PC and CSR values
CSR_AW, 12, CSR address width

Ports:
clock  input  1  system clock
reset  input  1  synchronous, active-high reset
req_valid  input  1  trap request from EXU
req_ready  output  1  high only in IDLE
req_kind  input  2  0=ecall, 1=ebreak, 2=mret, 3=reserved
req_pc  input  XLEN  PC of the trapping instruction
csr_raddr  output  CSR_AW  CSR read address; CSR file reads combinationally
csr_rdata  input  XLEN  CSR read data, same cycle
csr_waddr  output  CSR_AW  CSR write address
csr_wdata  output  XLEN  CSR write data
csr_wen  output  1  CSR write strobe; CSR file commits on the next clock edge
redir_valid  output  1  redirect PC available
redir_pc  output  XLEN  redirect target
redir_ready  input  1  IFU accepts redirect
busy  output  1  high in every state except IDLE

Behaviour:
- Clock port is clock; reset port is reset. Reset is synchronous and active-high.
- Reset: state=IDLE, csr_wen=0, redir_valid=0, redir_pc=0, latched pc/kind=0. Reset mid-sequence aborts it. CSR writes already committed stay; no further writes issue.
- Handshake: a request is accepted when req_valid&&req_ready. req_pc and req_kind are latched on acceptance.
- req_kind=3: accepted, then treated as a no-op. Return to IDLE the next cycle with no writes and no redirect.
- States and CSR addresses: IDLE, W_EPC, W_CAUSE, W_STAT, RD_TGT, REDIR. mepc=0x341, mcause=0x342, mstatus=0x300, mtvec=0x305.
- Ecall/ebreak path: IDLE -> W_EPC -> W_CAUSE -> W_STAT -> RD_TGT -> REDIR.
  - W_EPC: write mepc = pc & ~3.
  - W_CAUSE: write mcause = 11 (ecall) or 3 (ebreak).
  - W_STAT: csr_raddr=mstatus. Write new value: MPIE(bit7) <= old MIE(bit3), MIE <= 0, MPP(bits12:11) <= 2'b11, other bits unchanged.
  - RD_TGT: csr_raddr=mtvec. Latch redir_pc = rdata & ~3 (direct mode only; MODE bits ignored).
- Mret path: IDLE -> W_STAT -> RD_TGT -> REDIR.
  - W_STAT: MIE <= MPIE, MPIE <= 1, MPP <= 2'b11, other bits unchanged.
  - RD_TGT: csr_raddr=mepc. Latch redir_pc = rdata & ~3.
- csr_wen is asserted exactly one cycle in each W_* state and is 0 elsewhere. When csr_wen=0, csr_waddr and csr_wdata are don't-care.
- csr_raddr defaults to 0 outside W_STAT and RD_TGT.
- REDIR: redir_valid=1 with redir_pc stable until redir_ready. On the handshake cycle, go to IDLE; redir_valid drops the next cycle.
- Latency from acceptance to first redir_valid: ecall/ebreak = 5 cycles, mret = 3 cycles.
- A new request cannot be accepted in the same cycle as the redirect handshake; req_ready rises the following cycle.
- req_valid while busy is ignored. The requester must hold the request.
- All arithmetic is width-exact. No wrap concerns, since pc is only masked.

Decomposition:
- Shared package: CSR address constants (MSTATUS, MEPC, MCAUSE, MTVEC), cause codes (ECALL_M=11, BREAKPOINT=3), mstatus bit positions (MIE=3, MPIE=7, MPP=12:11), req_kind encodings, state enum.
- One natural sub-module, ysyx_25030093_mstatus_upd: combinational old mstatus + kind -> new mstatus. Tested standalone.

Test Plan:
- Ecall, pc=0x80000104, mstatus=0x0000_0008, mtvec=0x8000_0200 -> writes mepc=0x80000104, mcause=11, mstatus=0x0000_1880 in consecutive cycles; redir_pc=0x80000200 five cycles after accept.
- Mret, mstatus=0x0000_1880, mepc=0x80000108 -> single write mstatus=0x0000_1888; redir_pc=0x80000108 three cycles after accept.
- Ecall with req_pc=0x80000106, mtvec=0x80000203 -> mepc written 0x80000104, redir_pc=0x80000200.
- redir_ready held low 4 cycles in REDIR -> redir_valid and redir_pc stable; req_ready=0 throughout; req_ready=1 the cycle after the handshake.
- Reset asserted in W_CAUSE -> no mcause or mstatus write follows; next cycle state=IDLE, redir_valid=0, req_ready=1.
- req_kind=3 accepted -> zero csr_wen pulses, no redir_valid, req_ready=1 two cycles after accept.
